// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forwarding-select and hazard-control types for the pipeline
package pipe_pkg;
    localparam int REG_ZERO = 0;
    typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;
    typedef struct packed {
        logic if_id_flush;
        logic id_ex_flush;
        logic pc_write;
        logic if_id_write;
    } hz_ctrl_t;
    localparam hz_ctrl_t CTRL_BRANCH  = 4'b1111;
    localparam hz_ctrl_t CTRL_STALL   = 4'b0100;
    localparam hz_ctrl_t CTRL_JUMP    = 4'b1011;
    localparam hz_ctrl_t CTRL_DEFAULT = 4'b0011;
endpackage

// File: rtl/pipe_fwd_mux.sv
// pipe_fwd_mux: one ALU operand, EX/MEM over MEM/WB over register file
module pipe_fwd_mux import pipe_pkg::*; #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic          ex_mem_wr,
    input  logic [AW-1:0] ex_mem_addr,
    input  logic [DW-1:0] ex_mem_data,
    input  logic          mem_wb_wr,
    input  logic [AW-1:0] mem_wb_addr,
    input  logic [DW-1:0] mem_wb_data,
    input  logic [DW-1:0] rf,
    output logic [DW-1:0] data
);
    fwd_sel_t sel;
    always_comb begin
        sel = (ex_mem_wr && ex_mem_addr != AW'(REG_ZERO) && ex_mem_addr == src) ? FWD_EXMEM :
              (mem_wb_wr && mem_wb_addr != AW'(REG_ZERO) && mem_wb_addr == src) ? FWD_MEMWB : FWD_RF;
        data = sel == FWD_EXMEM ? ex_mem_data : sel == FWD_MEMWB ? mem_wb_data : rf;
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: operand forwarding, stall/flush control, mul/div busy tracking and stall counting
module pipe_hazard_unit import pipe_pkg::*; #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_mem_wr,
    input  logic [AW-1:0]    ex_mem_addr,
    input  logic [DW-1:0]    ex_mem_data,
    input  logic             mem_wb_wr,
    input  logic [AW-1:0]    mem_wb_addr,
    input  logic [DW-1:0]    mem_wb_data,
    input  logic [AW-1:0]    id_ex_rs,
    input  logic [AW-1:0]    id_ex_rt,
    input  logic [DW-1:0]    rf_a,
    input  logic [DW-1:0]    rf_b,
    output logic [DW-1:0]    data_a,
    output logic [DW-1:0]    data_b,
    input  logic             id_ex_mem_read,
    input  logic [AW-1:0]    if_id_rs,
    input  logic [AW-1:0]    if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             if_id_md_op,
    input  logic             md_start,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int MW = $clog2(MD_LAT + 1);
    logic [MW-1:0] md_cnt;
    logic load_use, md_hazard;
    hz_ctrl_t ctrl;
    pipe_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
        .src(id_ex_rs), .ex_mem_wr(ex_mem_wr), .ex_mem_addr(ex_mem_addr), .ex_mem_data(ex_mem_data),
        .mem_wb_wr(mem_wb_wr), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data), .rf(rf_a), .data(data_a)
    );
    pipe_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
        .src(id_ex_rt), .ex_mem_wr(ex_mem_wr), .ex_mem_addr(ex_mem_addr), .ex_mem_data(ex_mem_data),
        .mem_wb_wr(mem_wb_wr), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data), .rf(rf_b), .data(data_b)
    );
    always_comb begin
        load_use = id_ex_mem_read && id_ex_rt != AW'(REG_ZERO) &&
                   (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
        md_hazard = if_id_md_op && (md_busy || md_start);
        ctrl = reset ? CTRL_DEFAULT : branch_taken ? CTRL_BRANCH :
               (load_use || md_hazard) ? CTRL_STALL : jump ? CTRL_JUMP : CTRL_DEFAULT;
    end
    assign md_busy     = md_cnt != '0;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign pc_write    = ctrl.pc_write;
    assign if_id_write = ctrl.if_id_write;
    // a start while already busy simply restarts the full latency window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) md_cnt <= '0;
        else if (md_start) md_cnt <= MW'(MD_LAT);
        else if (md_busy) md_cnt <= md_cnt - MW'(1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt <= '0;
        else if (!ctrl.pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed vectors checked against a cycle-level model of the hazard rules
module tb_pipe_hazard_unit;
    logic clk = 0, reset = 1;
    logic ex_mem_wr = 0, mem_wb_wr = 0, id_ex_mem_read = 0, if_id_uses_rt = 0, if_id_md_op = 0;
    logic md_start = 0, branch_taken = 0, jump = 0;
    logic [4:0] ex_mem_addr = 0, mem_wb_addr = 0, id_ex_rs = 0, id_ex_rt = 0, if_id_rs = 0, if_id_rt = 0;
    logic [31:0] ex_mem_data = 0, mem_wb_data = 0, rf_a = 0, rf_b = 0;
    logic [31:0] data_a, data_b, s_data_a, s_data_b;
    logic if_id_flush, id_ex_flush, pc_write, if_id_write, md_busy;
    logic s_if_id_flush, s_id_ex_flush, s_pc_write, s_if_id_write, s_md_busy;
    logic [15:0] stall_cnt;
    logic [1:0] s_stall_cnt;
    int pass = 0, total = 0, cyc = 0, last_start = -100, sc = 0;

    pipe_hazard_unit dut (
        .clk(clk), .reset(reset), .ex_mem_wr(ex_mem_wr), .ex_mem_addr(ex_mem_addr), .ex_mem_data(ex_mem_data),
        .mem_wb_wr(mem_wb_wr), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data), .id_ex_rs(id_ex_rs),
        .id_ex_rt(id_ex_rt), .rf_a(rf_a), .rf_b(rf_b), .data_a(data_a), .data_b(data_b),
        .id_ex_mem_read(id_ex_mem_read), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_md_op(if_id_md_op), .md_start(md_start), .branch_taken(branch_taken), .jump(jump),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pc_write(pc_write), .if_id_write(if_id_write),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );
    pipe_hazard_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .ex_mem_wr(ex_mem_wr), .ex_mem_addr(ex_mem_addr), .ex_mem_data(ex_mem_data),
        .mem_wb_wr(mem_wb_wr), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data), .id_ex_rs(id_ex_rs),
        .id_ex_rt(id_ex_rt), .rf_a(rf_a), .rf_b(rf_b), .data_a(s_data_a), .data_b(s_data_b),
        .id_ex_mem_read(id_ex_mem_read), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_md_op(if_id_md_op), .md_start(md_start), .branch_taken(branch_taken), .jump(jump),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (ex_mem_wr && ex_mem_addr != 0 && ex_mem_addr == src) return ex_mem_data;
        if (mem_wb_wr && mem_wb_addr != 0 && mem_wb_addr == src) return mem_wb_data;
        return rf;
    endfunction

    function automatic logic model_busy();
        return cyc > last_start && cyc <= last_start + 4;
    endfunction

    // {if_id_flush, id_ex_flush, pc_write, if_id_write}
    function automatic logic [3:0] exp_ctrl();
        logic lu, mdh;
        lu  = id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
        mdh = if_id_md_op && (model_busy() || md_start);
        if (reset) return 4'b0011;
        if (branch_taken) return 4'b1111;
        if (lu || mdh) return 4'b0100;
        if (jump) return 4'b1011;
        return 4'b0011;
    endfunction

    always @(negedge clk) begin
        logic [3:0] ec;
        if (reset) begin
            sc = 0;
            last_start = -100;
        end
        ec = exp_ctrl();
        chk("data_a", data_a, fwd(id_ex_rs, rf_a));
        chk("data_b", data_b, fwd(id_ex_rt, rf_b));
        chk("ctrl", {if_id_flush, id_ex_flush, pc_write, if_id_write}, ec);
        chk("md_busy", md_busy, model_busy());
        chk("stall_cnt", stall_cnt, sc);
        chk("s_ctrl", {s_if_id_flush, s_id_ex_flush, s_pc_write, s_if_id_write}, ec);
        chk("s_stall_cnt", s_stall_cnt, sc > 3 ? 3 : sc);
        if (!reset) begin
            if (!ec[1]) sc++;
            if (md_start) last_start = cyc;
        end
    end

    task automatic at_neg();
        @(negedge clk); #1;
    endtask
    task automatic next();
        @(posedge clk); #1;
    endtask
    task automatic clr();
        {ex_mem_wr, mem_wb_wr, id_ex_mem_read, if_id_uses_rt, if_id_md_op, md_start, branch_taken, jump} = '0;
        {ex_mem_addr, mem_wb_addr, id_ex_rs, id_ex_rt, if_id_rs, if_id_rt} = '0;
        {ex_mem_data, mem_wb_data, rf_b} = '0;
        rf_a = 32'h0000_AAAA;
    endtask

    initial begin
        clr();
        id_ex_mem_read = 1; id_ex_rt = 5; if_id_rs = 5; branch_taken = 1;
        at_neg();
        chk("rst_ctrl", {if_id_flush, id_ex_flush, pc_write, if_id_write}, 4'b0011);
        chk("rst_data_a", data_a, 32'h0000_AAAA);
        chk("rst_busy", md_busy, 0);
        chk("rst_cnt", stall_cnt, 0);
        next(); clr(); next();
        reset = 0;
        ex_mem_wr = 1; ex_mem_addr = 8; ex_mem_data = 32'h11;
        mem_wb_wr = 1; mem_wb_addr = 8; mem_wb_data = 32'h22; id_ex_rs = 8; rf_a = 32'hA;
        at_neg(); chk("fwd_exmem", data_a, 32'h11);
        next(); ex_mem_wr = 0;
        at_neg(); chk("fwd_memwb", data_a, 32'h22);
        next(); ex_mem_wr = 1; ex_mem_addr = 0; ex_mem_data = 32'h55;
        mem_wb_wr = 1; mem_wb_addr = 0; mem_wb_data = 32'h33; id_ex_rt = 0; rf_b = 0;
        at_neg(); chk("no_fwd_r0", data_b, 32'h0);
        next(); ex_mem_addr = 9; ex_mem_wr = 0; mem_wb_addr = 9; mem_wb_data = 32'h99; id_ex_rt = 9; rf_b = 32'h7;
        at_neg(); chk("fwd_b_memwb", data_b, 32'h99);
        next(); clr(); id_ex_mem_read = 1; id_ex_rt = 5; if_id_rs = 5;
        at_neg();
        chk("lu_ctrl", {if_id_flush, id_ex_flush, pc_write, if_id_write}, 4'b0100);
        chk("lu_cnt0", stall_cnt, 0);
        next(); clr();
        at_neg();
        chk("lu_done", pc_write, 1);
        chk("lu_cnt1", stall_cnt, 1);
        next(); id_ex_mem_read = 1; id_ex_rt = 5; if_id_rt = 5; if_id_uses_rt = 0;
        at_neg(); chk("rt_unused", pc_write, 1);
        next(); if_id_uses_rt = 1;
        at_neg(); chk("rt_used", pc_write, 0);
        next(); clr(); id_ex_mem_read = 1; id_ex_rt = 0; if_id_rs = 0;
        at_neg(); chk("lu_r0", pc_write, 1);
        next(); id_ex_rt = 5; if_id_rs = 5; branch_taken = 1;
        at_neg(); chk("br_wins", {if_id_flush, id_ex_flush, pc_write, if_id_write}, 4'b1111);
        next(); clr(); jump = 1;
        at_neg();
        chk("jump", {if_id_flush, id_ex_flush, pc_write, if_id_write}, 4'b1011);
        chk("br_nocount", stall_cnt, 2);
        next(); clr(); md_start = 1; if_id_md_op = 1;
        for (int i = 0; i < 5; i++) begin
            at_neg(); chk("md_stall", pc_write, 0);
            next(); md_start = 0;
        end
        at_neg();
        chk("md_proceed", pc_write, 1);
        chk("md_idle", md_busy, 0);
        chk("md_cnt7", stall_cnt, 7);
        chk("sat3", s_stall_cnt, 3);
        next(); clr(); md_start = 1;
        next(); md_start = 0;
        next(); #2;
        chk("busy_pre_rst", md_busy, 1);
        reset = 1; #1;
        chk("async_busy", md_busy, 0);
        chk("async_cnt", stall_cnt, 0);
        at_neg(); reset = 0;
        next(); id_ex_mem_read = 1; id_ex_rt = 6; if_id_rs = 6;
        for (int i = 0; i < 5; i++) next();
        clr();
        at_neg();
        chk("cnt5", stall_cnt, 5);
        chk("sat_again", s_stall_cnt, 3);
        next(); next();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised forwarding and hazard-control unit for the 5-stage MIPS pipeline. It replaces the separate combinational forward and hazard logic. It adds a multi-cycle multiply/divide (HI/LO) busy tracker and a saturating stall-cycle performance counter. It sits beside the ID and EX stages: it drives the ALU operand muxes and the PC, IF/ID and ID/EX write/flush controls.

## Interface
Parameters:
- DW, 32, datapath width
- AW, 5, register address width
- MD_LAT, 4, cycles the mul/div unit stays busy after issue (≥1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- ex_mem_wr  in  1  EX/MEM register-file write enable
- ex_mem_addr  in  AW  EX/MEM destination register
- ex_mem_data  in  DW  EX/MEM ALU result
- mem_wb_wr  in  1  MEM/WB write enable
- mem_wb_addr  in  AW  MEM/WB destination register
- mem_wb_data  in  DW  MEM/WB write-back data
- id_ex_rs, id_ex_rt  in  AW  EX-stage source registers
- rf_a, rf_b  in  DW  register-file read data for the EX instruction
- data_a, data_b  out  DW  forwarded ALU operands
- id_ex_mem_read  in  1  EX-stage instruction is a load
- if_id_rs, if_id_rt  in  AW  ID-stage source registers
- if_id_uses_rt  in  1  ID instruction reads rt
- if_id_md_op  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- md_start  in  1  mult/div issued from EX this cycle
- branch_taken  in  1  branch resolved taken in EX
- jump  in  1  jump decoded in ID
- if_id_flush, id_ex_flush, pc_write, if_id_write  out  1  pipeline controls
- md_busy  out  1  mul/div unit busy
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Forwarding (combinational, per operand): a match requires the write enable, a non-zero destination address, and destination == source.
  - Sources are id_ex_rs for data_a and id_ex_rt for data_b.
  - Priority is EX/MEM over MEM/WB over the register file.
  - Register 0 is never forwarded.
- Load-use hazard: asserted when id_ex_mem_read is 1, id_ex_rt is non-zero, and id_ex_rt equals if_id_rs, or equals if_id_rt with if_id_uses_rt set.
- MD hazard: asserted when if_id_md_op is 1 and either md_busy or md_start is 1.
- Control priority, highest first:
  - branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1.
  - load-use or MD hazard: if_id_flush=0, id_ex_flush=1, pc_write=0, if_id_write=0.
  - jump: if_id_flush=1, id_ex_flush=0, pc_write=1, if_id_write=1.
  - default: if_id_flush=0, id_ex_flush=0, pc_write=1, if_id_write=1.
- MD busy counter (md_cnt, width $clog2(MD_LAT+1)):
  - md_start loads MD_LAT.
  - Otherwise md_cnt decrements while non-zero.
  - md_busy = (md_cnt != 0).
  - md_start while busy reloads MD_LAT. This is a protocol violation, but the behaviour is defined.
- Stall counter: stall_cnt increments in each cycle where pc_write==0. It holds at all-ones and does not wrap.

## Timing
- Reset (asynchronous, active-high): md_cnt=0, md_busy=0, stall_cnt=0.
- During reset, the control outputs take their default values (pc_write=1, if_id_write=1, both flushes 0). data_a and data_b follow rf_a and rf_b unless a forward matches.
- Forwarding and control outputs are combinational from current inputs, with zero-cycle latency.
- md_start sampled high at edge t: md_busy is high for cycles t+1 … t+MD_LAT and low at t+MD_LAT+1.
- MD stall covers the issue cycle and all busy cycles. An MD op in ID proceeds in the first cycle that md_busy is 0 and md_start is 0.
- Simultaneous branch_taken and hazard: the branch wins and no stall is counted.
- Reset asserted mid-busy clears md_cnt immediately. md_busy drops without waiting for a clock edge.

## Structure
- Shared package pipe_pkg:
  - REG_ZERO constant
  - fwd_sel_t enum {FWD_RF, FWD_EXMEM, FWD_MEMWB}
  - hazard control struct {if_id_flush, id_ex_flush, pc_write, if_id_write}
- Sub-module pipe_fwd_mux (select logic plus DW-wide 3:1 mux), instantiated once per operand.
- md counter, stall counter and priority logic live in the top module.

## Test plan
- EX/MEM and MEM/WB both write r8 (0x11, 0x22), id_ex_rs=8 -> data_a=0x11. With ex_mem_wr=0 -> data_a=0x22.
- ex_mem_wr=1, ex_mem_addr=0, id_ex_rt=0, rf_b=0 -> data_b=0 (no forward of r0).
- Load to r5 in EX, if_id_rs=5 -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle; stall_cnt 0->1.
- MD_LAT=4: md_start at cycle 0, if_id_md_op=1 held -> stall in cycles 0–4, proceed at cycle 5; stall_cnt=5.
- branch_taken coincident with load-use hazard -> both flushes 1, pc_write=1, stall_cnt unchanged.
- Reset pulse at cycle 2 of an MD busy window -> md_busy=0 asynchronously. CNT_W=2 with 5 stall cycles -> stall_cnt saturates at 3.
